bg_pixel_fetcher: RTL and testbench
===================================

# bg_pixel_fetcher

Background pixel fetcher and pixel FIFO for the PPU Draw mode (mode 3). It is started by the PPU mode sequencer at the OAM Scan to Draw transition. It walks the background tile map for the current scanline, fetches tile rows from VRAM and pushes 8 decoded pixels at a time into an internal FIFO. It pops one palette-mapped pixel per T-cycle toward the LCD and reports end-of-line so the sequencer can enter HBlank.

## Interface
- FIFO_DEPTH, 16, pixel FIFO entries; must be ≥ 9.
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- tclk_in  input  1  T-cycle enable strobe. All state advances only on clk_in edges where tclk_in=1, except data capture.
- start_in  input  1  start of Draw for this line; sampled on a T-edge.
- LY_in  input  8  current scanline.
- SCY_in, SCX_in  input  8 each  scroll registers.
- LCDC_in  input  8  bit0 BG enable; bit3 BG map select; bit4 tile data addressing.
- BGP_in  input  8  BG palette.
- addr_out  output  16  VRAM address.
- addr_valid_out  output  1  request strobe; address held stable while high.
- data_in  input  8  VRAM read data.
- data_valid_in  input  1  data_in valid; sampled on any clk_in edge while addr_valid_out=1.
- pixel_out  output  2  shade 0–3.
- pixel_valid_out  output  1  pixel_out is a visible pixel; high for exactly one T-cycle per pixel.
- X_out  output  8  count of pixels output this line (0–160).
- line_done_out  output  1  one-T-cycle pulse after pixel 159.

## Operation
- States: Idle, TileNum, DataLow, DataHigh, Push, Done.
- Reset forces Idle; all outputs are 0; the FIFO is empty.
- start_in in any state clears the FIFO, tile_idx, X and the discard counter, then enters TileNum. This also covers a mid-line restart.
- Each fetch state:
  - Asserts addr_valid_out on entry.
  - Captures data_in on the first clk_in edge with data_valid_in=1, then drops addr_valid_out.
  - Leaves on the first T-edge at which data has been captured and ≥2 T-cycles have elapsed in the state.
- Address arithmetic, all 8-bit wraps:
  - row = (LY_in+SCY_in); col = ((SCX_in>>3)+tile_idx)&31.
  - TileNum: (LCDC_in[3] ? 16'h9C00 : 16'h9800) + row[7:3]*32 + col.
  - Data base: LCDC_in[4] ? 16'h8000 + tile*16 : 16'h9000 + signed(tile)*16.
  - DataLow = base + row[2:0]*2; DataHigh = DataLow + 1.
- Push:
  - Waits in Push until count ≤ FIFO_DEPTH-8.
  - Then writes 8 pixels in one T-edge, left to right. Pixel i colour = {high[7-i], low[7-i]}.
  - Increments tile_idx (5-bit wrap) and returns to TileNum.
- Pop:
  - Each T-edge with count>0, state ≠ Idle/Done, and X<160 pops one pixel.
  - A simultaneous push and pop gives count+7.
  - Popped pixels are first consumed by the discard counter. While discard>0, a pop decrements discard with no pixel_valid_out.
  - Otherwise pixel_out = LCDC_in[0] ? BGP_in[2c+1 -: 2] : 2'b00; pixel_valid_out=1; X increments.
- When X reaches 160:
  - Pulse line_done_out.
  - Drop any pending request.
  - Flush the FIFO.
  - Enter Done, which is held until start_in.
- FIFO overflow or underflow never occurs. An empty FIFO simply stalls output (pixel_valid_out=0).

## Timing
- With zero-wait memory (data_valid_in same cycle), per tile: TileNum 2 + DataLow 2 + DataHigh 2 + Push 1 = 7 T-cycles.
- start_in at T-edge t0:
  - Requests at t0+1, t0+3, t0+5.
  - Push at t0+7.
  - First pop at t0+8.
  - First pixel_valid_out at t0+8+(SCX&7).
- Steady state: one pixel per T-cycle once the FIFO primes. Fetch is 7/tile, output is 8/tile, so the FIFO fills and Push waits.
- Line length from start_in to line_done_out with zero-wait memory: 8+(SCX&7)+160 T-cycles. line_done_out rises on the T-edge after the 160th pixel.
- Memory wait states lengthen the fetch state. Output stalls only if the FIFO drains.
- Outputs are registered: pixel_out and pixel_valid_out update on the popping T-edge.

## Configuration
- PPU_FINE_SCROLL_EN defined: the discard counter is loaded with SCX_in[2:0] at start_in.
- PPU_FINE_SCROLL_EN undefined: the discard counter is tied to 0 and scrolling is tile-granular only. Latency to the first pixel is t0+8 regardless of SCX.

## Test plan
- Reset asserted mid-Push: all outputs read 0 immediately (asynchronous reset). After release, the block idles until start_in.
- Zero-wait memory, SCX=0, SCY=0, LY=0, LCDC=0x91, BGP=0xE4:
  - First address is 0x9800.
  - Tile 0x01 gives data addresses 0x8010/0x8011.
  - Data 0xFF/0x00 gives eight pixels of shade 1.
  - line_done_out occurs at t0+168.
- LCDC[4]=0, tile number 0x80 → DataLow address 0x8800.
- SCX=0x0B with PPU_FINE_SCROLL_EN: first map address is 0x9801, 3 pixels are discarded, first pixel_valid_out at t0+11. Without the macro: t0+8.
- Memory with 3-cycle data_valid_in delay on every request: pixel_valid_out has gaps; X_out ends at exactly 160; no FIFO overflow.
- start_in reasserted at X=50: X_out returns to 0, the FIFO is flushed, and fetching restarts at col SCX>>3.

Source files
------------

// File: rtl/bg_pixel_fetcher.sv
// Background tile fetcher and pixel FIFO for PPU Draw mode.
// Define PPU_FINE_SCROLL_EN to discard SCX[2:0] pixels at line start.
module bg_pixel_fetcher #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic        start_in,
  input  logic [7:0]  LY_in,
  input  logic [7:0]  SCY_in,
  input  logic [7:0]  SCX_in,
  input  logic [7:0]  LCDC_in,
  input  logic [7:0]  BGP_in,
  output logic [15:0] addr_out,
  output logic        addr_valid_out,
  input  logic [7:0]  data_in,
  input  logic        data_valid_in,
  output logic [1:0]  pixel_out,
  output logic        pixel_valid_out,
  output logic [7:0]  X_out,
  output logic        line_done_out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TILE,
    S_LOW,
    S_HIGH,
    S_PUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_req;
  logic          r_got;
  logic          r_tcnt;
  logic [7:0]    r_tile;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [4:0]    r_tidx;
  logic [2:0]    r_disc;
  logic [7:0]    r_x;
  logic [CW-1:0] r_count;
  logic [1:0]    r_fifo [FIFO_DEPTH];
  logic [1:0]    r_pix;
  logic          r_pvalid;
  logic          r_ldone;

  logic          w_active;
  logic          w_cap;
  logic          w_ready;
  logic          w_end;
  logic          w_room;
  logic          w_pop;
  logic          w_push;
  logic          w_show;
  logic          w_next_fetch;
  logic          w_enter;
  logic [2:0]    w_disc_init;
  logic [1:0]    w_shade;
  logic [7:0]    w_row;
  logic [4:0]    w_col;
  logic [15:0]   w_map;
  logic [15:0]   w_base;
  logic [15:0]   w_low;
  logic [AW-1:0] w_widx [8];
  logic [1:0]    w_wpix [8];
  logic          w_unused;

`ifdef PPU_FINE_SCROLL_EN
  assign w_disc_init = SCX_in[2:0];
  assign w_unused = ^{LCDC_in[7:5], LCDC_in[2:1]};
`else
  assign w_disc_init = 3'd0;
  assign w_unused = ^{LCDC_in[7:5], LCDC_in[2:1], SCX_in[2:0]};
`endif

  assign w_active = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_cap    = r_req && data_valid_in;
  assign w_ready  = (r_got || w_cap) && r_tcnt;
  assign w_end    = w_active && (r_x == 8'd160);
  assign w_room   = r_count <= CW'(FIFO_DEPTH - 8);

  assign w_pop = tclk_in && !start_in && w_active
              && (r_x < 8'd160) && (r_count != '0);
  assign w_push = tclk_in && !start_in && !w_end
               && (r_state == S_PUSH) && w_room;
  assign w_show = w_pop && (r_disc == 3'd0);

  assign w_shade = LCDC_in[0]
                 ? BGP_in[{1'b0, r_fifo[0], 1'b0} +: 2]
                 : 2'b00;

  always_comb begin
    w_next = r_state;
    if (tclk_in) begin
      if (start_in) begin
        w_next = S_TILE;
      end else if (w_end) begin
        w_next = S_DONE;
      end else begin
        unique case (r_state)
          S_TILE:  if (w_ready) w_next = S_LOW;
          S_LOW:   if (w_ready) w_next = S_HIGH;
          S_HIGH:  if (w_ready) w_next = S_PUSH;
          S_PUSH:  if (w_room) w_next = S_TILE;
          default: w_next = r_state;
        endcase
      end
    end
  end

  assign w_next_fetch = (w_next == S_TILE)
                     || (w_next == S_LOW)
                     || (w_next == S_HIGH);
  assign w_enter = tclk_in && w_next_fetch
                && (start_in || (w_next != r_state));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Map and tile-data addresses; all byte arithmetic wraps.
  assign w_row = LY_in + SCY_in;
  assign w_col = SCX_in[7:3] + r_tidx;
  assign w_map = (LCDC_in[3] ? 16'h9C00 : 16'h9800)
               + {6'd0, w_row[7:3], w_col};
  assign w_base = LCDC_in[4]
                ? 16'h8000 + {4'd0, r_tile, 4'd0}
                : 16'h9000 + {{4{r_tile[7]}}, r_tile, 4'd0};
  assign w_low = w_base + {12'd0, w_row[2:0], 1'b0};

  always_comb begin
    addr_out = 16'h0000;
    unique case (r_state)
      S_TILE:  addr_out = w_map;
      S_LOW:   addr_out = w_low;
      S_HIGH:  addr_out = w_low + 16'd1;
      default: addr_out = 16'h0000;
    endcase
  end

  // Data is captured on any clock edge; the state only moves on T-edges.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_req  <= 1'b0;
      r_got  <= 1'b0;
      r_tcnt <= 1'b0;
      r_tile <= 8'd0;
      r_lo   <= 8'd0;
      r_hi   <= 8'd0;
    end else begin
      if (w_cap) begin
        r_req <= 1'b0;
        r_got <= 1'b1;
        if (r_state == S_TILE) r_tile <= data_in;
        if (r_state == S_LOW)  r_lo   <= data_in;
        if (r_state == S_HIGH) r_hi   <= data_in;
      end
      if (tclk_in) begin
        if (w_enter) begin
          r_req  <= 1'b1;
          r_got  <= 1'b0;
          r_tcnt <= 1'b0;
        end else if (w_next_fetch) begin
          r_tcnt <= 1'b1;
        end else begin
          r_req  <= 1'b0;
          r_got  <= 1'b0;
          r_tcnt <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_widx[i] = AW'(int'(r_count) - int'(w_pop) + i);
      w_wpix[i] = {r_hi[3'(7 - i)], r_lo[3'(7 - i)]};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count  <= '0;
      r_tidx   <= 5'd0;
      r_disc   <= 3'd0;
      r_x      <= 8'd0;
      r_pix    <= 2'b00;
      r_pvalid <= 1'b0;
      r_ldone  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 2'b00;
    end else if (tclk_in) begin
      r_pvalid <= w_show;
      r_pix    <= w_show ? w_shade : 2'b00;
      r_ldone  <= w_end && !start_in;
      if (start_in) begin
        r_count <= '0;
        r_tidx  <= 5'd0;
        r_x     <= 8'd0;
        r_disc  <= w_disc_init;
      end else if (w_end) begin
        r_count <= '0;
      end else begin
        if (w_pop) begin
          for (int i = 0; i < FIFO_DEPTH - 1; i++)
            r_fifo[i] <= r_fifo[i + 1];
          r_fifo[FIFO_DEPTH - 1] <= 2'b00;
          if (r_disc != 3'd0) r_disc <= r_disc - 3'd1;
          else                r_x    <= r_x + 8'd1;
        end
        // Push lands behind whatever survives this edge's pop.
        if (w_push) begin
          for (int i = 0; i < 8; i++)
            r_fifo[w_widx[i]] <= w_wpix[i];
          r_tidx <= r_tidx + 5'd1;
        end
        r_count <= r_count
                 + (w_push ? CW'(8) : CW'(0))
                 - (w_pop ? CW'(1) : CW'(0));
      end
    end
  end

  assign addr_valid_out  = r_req;
  assign pixel_out       = r_pix;
  assign pixel_valid_out = r_pvalid;
  assign X_out           = r_x;
  assign line_done_out   = r_ldone;

endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// Bench for bg_pixel_fetcher: VRAM model with wait states and
// a per-pixel reference computed from tile-map arithmetic.
`timescale 1ns/1ps
module tb_bg_pixel_fetcher;

`ifdef PPU_FINE_SCROLL_EN
  localparam int FINE = 1;
`else
  localparam int FINE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        tclk_in = 1'b1;
  logic        start_in = 1'b0;
  logic [7:0]  LY = 8'd0;
  logic [7:0]  SCY = 8'd0;
  logic [7:0]  SCX = 8'd0;
  logic [7:0]  LCDC = 8'd0;
  logic [7:0]  BGP = 8'd0;
  logic [15:0] addr_out;
  logic        addr_valid_out;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid_in = 1'b0;
  logic [1:0]  pixel_out;
  logic        pixel_valid_out;
  logic [7:0]  X_out;
  logic        line_done_out;

  bg_pixel_fetcher #(.FIFO_DEPTH(16)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .tclk_in         (tclk_in),
    .start_in        (start_in),
    .LY_in           (LY),
    .SCY_in          (SCY),
    .SCX_in          (SCX),
    .LCDC_in         (LCDC),
    .BGP_in          (BGP),
    .addr_out        (addr_out),
    .addr_valid_out  (addr_valid_out),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .X_out           (X_out),
    .line_done_out   (line_done_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;
  int tnow = 0;
  int t0 = 0;
  int pq[$];
  int ptq[$];
  int aq[$];
  int done_t = -1;
  int done_cnt = 0;
  bit req_start = 0;
  bit start_seen = 0;
  bit need_log = 0;
  bit logged = 0;
  bit tclk_rand = 0;
  bit mem_rand = 0;
  int mem_delay = 0;
  int cur_delay = 0;
  int wcnt = 0;
  int nsave;

  // Stimulus drive and VRAM responder, all on the falling edge.
  always @(negedge clk) begin
    tclk_in = tclk_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (req_start && tclk_in) begin
      start_in = 1'b1;
      req_start = 0;
    end else begin
      start_in = 1'b0;
    end
    if (addr_valid_out) begin
      if (wcnt >= cur_delay) begin
        data_valid_in = 1'b1;
        data_in = mem[addr_out];
        if (!logged || need_log) begin
          aq.push_back(int'(addr_out));
          logged = 1;
          need_log = 0;
        end
      end else begin
        data_valid_in = 1'b0;
        wcnt++;
      end
    end else begin
      data_valid_in = 1'b0;
      data_in = 8'd0;
      wcnt = 0;
      logged = 0;
      cur_delay = mem_rand ? int'($urandom_range(0, 4)) : mem_delay;
    end
  end

  // Output monitor: T-edge stamps are relative to the start edge.
  always @(posedge clk) begin
    if (tclk_in && !rst_in) begin
      tnow++;
      if (start_in) begin
        t0 = tnow;
        pq.delete();
        ptq.delete();
        aq.delete();
        done_t = -1;
        done_cnt = 0;
        start_seen = 1;
        need_log = 1;
      end
      #1;
      if (pixel_valid_out) begin
        pq.push_back(int'(pixel_out));
        ptq.push_back(tnow - t0);
      end
      if (line_done_out) begin
        done_cnt++;
        done_t = tnow - t0;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int map_addr(input int t);
    int row;
    int col;
    row = (int'(LY) + int'(SCY)) % 256;
    col = (int'(SCX) / 8 + t) % 32;
    return (LCDC[3] ? 'h9C00 : 'h9800) + (row / 8) * 32 + col;
  endfunction

  function automatic int low_addr(input int tn);
    int row;
    int b;
    row = (int'(LY) + int'(SCY)) % 256;
    if (LCDC[4]) b = 'h8000 + tn * 16;
    else         b = 'h9000 + ((tn >= 128) ? tn - 256 : tn) * 16;
    return (b + (row % 8) * 2) & 'hFFFF;
  endfunction

  function automatic int exp_pix(input int x);
    int k;
    int tn;
    int la;
    int lo;
    int hi;
    int b;
    int c;
    k = x + (FINE != 0 ? int'(SCX) % 8 : 0);
    tn = int'(mem[map_addr(k / 8)]);
    la = low_addr(tn);
    lo = int'(mem[la]);
    hi = int'(mem[(la + 1) & 'hFFFF]);
    b = 7 - (k % 8);
    c = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
    return LCDC[0] ? (int'(BGP) >> (2 * c)) & 3 : 0;
  endfunction

  task automatic start_line();
    @(posedge clk);
    #2;
    start_seen = 0;
    req_start = 1;
    for (int i = 0; i < 200 && !start_seen; i++) @(negedge clk);
    chk("start_taken", int'(start_seen), 1);
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while (done_cnt == 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("line_done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_line(input string tag);
    chk({tag, "_x_end"}, int'(X_out), 160);
    chk({tag, "_npix"}, pq.size(), 160);
    chk({tag, "_one_pulse"}, done_cnt, 1);
    for (int i = 0; i < pq.size() && i < 160; i++)
      chk($sformatf("%s_pix%0d", tag, i), pq[i], exp_pix(i));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pixel"}, int'(pixel_out), 0);
    chk({tag, "_pvalid"}, int'(pixel_valid_out), 0);
    chk({tag, "_x"}, int'(X_out), 0);
    chk({tag, "_ldone"}, int'(line_done_out), 0);
    chk({tag, "_avalid"}, int'(addr_valid_out), 0);
    chk({tag, "_addr"}, int'(addr_out), 0);
  endtask

  initial begin
    int d;
    int i;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    #1 rst_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_no_req", int'(addr_valid_out), 0);
    chk("idle_no_pix", pq.size(), 0);

    // Zero-wait basic line
    LY = 8'd0; SCY = 8'd0; SCX = 8'd0; LCDC = 8'h91; BGP = 8'hE4;
    mem['h9800] = 8'h01; mem['h8010] = 8'hFF; mem['h8011] = 8'h00;
    start_line();
    wait_done(3000);
    chk("a_map_addr", aq[0], 'h9800);
    chk("a_low_addr", aq[1], 'h8010);
    chk("a_high_addr", aq[2], 'h8011);
    for (int k = 0; k < 8; k++) chk($sformatf("a_shade1_%0d", k), pq[k], 1);
    chk("a_first_pix_t", ptq[0], 8);
    chk("a_last_pix_t", ptq[159], 167);
    chk("a_done_t", done_t, 168);
    check_line("a");

    // Signed tile-data addressing
    LCDC = 8'h81; mem['h9800] = 8'h80;
    start_line();
    wait_done(3000);
    chk("b_low_addr", aq[1], 'h8800);
    check_line("b");

    // Fine scroll
    LCDC = 8'h91; SCX = 8'h0B; BGP = 8'($urandom);
    d = (FINE != 0) ? 3 : 0;
    start_line();
    wait_done(3000);
    chk("c_map_addr", aq[0], 'h9801);
    chk("c_first_pix_t", ptq[0], 8 + d);
    chk("c_done_t", done_t, 168 + d);
    check_line("c");

    // Three wait states on every request
    mem_delay = 3;
    LY = 8'($urandom); SCY = 8'($urandom); SCX = 8'($urandom);
    start_line();
    wait_done(6000);
    chk("d_has_gaps", (ptq[159] - ptq[0] > 159) ? 1 : 0, 1);
    check_line("d");
    mem_delay = 0;

    // Random config, random T-strobe and random wait states
    tclk_rand = 1; mem_rand = 1;
    for (int r = 0; r < 3; r++) begin
      LY = 8'($urandom); SCY = 8'($urandom); SCX = 8'($urandom);
      LCDC = 8'($urandom); BGP = 8'($urandom);
      start_line();
      wait_done(8000);
      check_line($sformatf("r%0d", r));
    end
    tclk_rand = 0; mem_rand = 0;

    // Mid-line restart
    LY = 8'($urandom); SCY = 8'($urandom); SCX = 8'($urandom);
    LCDC = 8'h91 | 8'($urandom & 8'h18); BGP = 8'($urandom);
    start_line();
    i = 0;
    while (X_out < 8'd50 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("f_reached_50", (X_out >= 8'd50) ? 1 : 0, 1);
    start_line();
    chk("f_x_cleared", int'(X_out), 0);
    chk("f_pvalid_low", int'(pixel_valid_out), 0);
    wait_done(3000);
    chk("f_restart_col", aq[0], map_addr(0));
    check_line("f");

    // Asynchronous reset mid-line
    start_line();
    i = 0;
    while (X_out < 8'd30 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    chk("g_reached_30", (X_out >= 8'd30) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst_in = 1'b1;
    #1 chk_zero("g_async");
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    nsave = pq.size();
    repeat (40) @(negedge clk);
    chk("g_idle_req", int'(addr_valid_out), 0);
    chk("g_idle_x", int'(X_out), 0);
    chk("g_idle_pix", pq.size(), nsave);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
